// File: rtl/uart_tx_ctrl_if.sv
// Handshake bundle between a byte producer and the UART transmit controller.
// The producer drives data/valid; the controller answers with ready.
interface uart_tx_ctrl_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts one word over a valid/ready handshake
// and serialises it as start, LSB-first data, optional parity and 1 or 2
// stop bits, advancing one bit per baud_tick. All outputs are registered.
module uart_tx_ctrl #(
    parameter int DATA_BITS  = 8,   // 5..8
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1    // 1 or 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           baud_tick,
    uart_tx_ctrl_if.slave  bus,
    output logic           tx_serial,
    output logic           busy,
    output logic           tx_done
);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 r_stop_cnt;
    logic                 r_parity;
    logic                 r_tx_serial;
    logic                 r_tx_ready;
    logic                 r_busy;
    logic                 r_tx_done;
    logic                 w_accept;

    // Parity of the payload, inverted for odd parity.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY_ODD != 0) ? ~(^d) : (^d);
    endfunction

    // Ready is registered, so accept only depends on the registered ready.
    assign w_accept     = bus.tx_valid & r_tx_ready;
    assign bus.tx_ready = r_tx_ready;
    assign tx_serial    = r_tx_serial;
    assign busy         = r_busy;
    assign tx_done      = r_tx_done;

    // Frame sequencer: state, shift register, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_stop_cnt  <= 1'b0;
            r_parity    <= 1'b0;
            r_tx_serial <= 1'b1;
            r_tx_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx_serial <= 1'b1;
                    if (w_accept) begin
                        // A tick coinciding with accept is deliberately ignored:
                        // ARMED waits for the next one so the start bit is full length.
                        r_shift    <= bus.tx_data;
                        r_parity   <= parity_of(bus.tx_data);
                        r_bit_idx  <= '0;
                        r_stop_cnt <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_ARMED;
                    end else begin
                        r_tx_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (baud_tick) begin
                        r_tx_serial <= 1'b0;
                        r_state     <= S_START;
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        r_tx_serial <= r_shift[0];
                        r_bit_idx   <= '0;
                        r_state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        if (r_bit_idx == LAST_IDX) begin
                            if (PARITY_EN != 0) begin
                                r_tx_serial <= r_parity;
                                r_state     <= S_PARITY;
                            end else begin
                                r_tx_serial <= 1'b1;
                                r_stop_cnt  <= 1'b0;
                                r_state     <= S_STOP;
                            end
                        end else begin
                            // Next line level is the bit that becomes the new LSB.
                            r_tx_serial <= r_shift[1];
                            r_shift     <= {1'b0, r_shift[DATA_BITS-1:1]};
                            r_bit_idx   <= r_bit_idx + IDX_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_tick) begin
                        r_tx_serial <= 1'b1;
                        r_stop_cnt  <= 1'b0;
                        r_state     <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (baud_tick) begin
                        if (r_stop_cnt == LAST_STOP) begin
                            // Ready rises together with done so a waiting
                            // requester can start the next frame immediately.
                            r_tx_serial <= 1'b1;
                            r_tx_done   <= 1'b1;
                            r_tx_ready  <= 1'b1;
                            r_busy      <= 1'b0;
                            r_stop_cnt  <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx_serial <= 1'b1;
                    r_tx_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: three configurations share one stimulus stream and
// are compared every cycle against a frame-level model, plus literal checks.
module tb_uart_tx_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tick_mode = 1'b0;
    logic       capture = 1'b0;

    int total = 0;
    int bad = 0;

    logic s0, s1, s2, b0, b1, b2, d0, d1, d2;
    logic [2:0] ser_v, bsy_v, dn_v, rdy_v;

    uart_tx_ctrl_if #(.DATA_BITS(8)) if0 ();
    uart_tx_ctrl_if #(.DATA_BITS(8)) if1 ();
    uart_tx_ctrl_if #(.DATA_BITS(8)) if2 ();

    assign if0.tx_data = tx_data;  assign if0.tx_valid = tx_valid;
    assign if1.tx_data = tx_data;  assign if1.tx_valid = tx_valid;
    assign if2.tx_data = tx_data;  assign if2.tx_valid = tx_valid;

    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .bus(if0.slave),
        .tx_serial(s0), .busy(b0), .tx_done(d0));
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .bus(if1.slave),
        .tx_serial(s1), .busy(b1), .tx_done(d1));
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .bus(if2.slave),
        .tx_serial(s2), .busy(b2), .tx_done(d2));

    assign ser_v = {s2, s1, s0};
    assign bsy_v = {b2, b1, b0};
    assign dn_v  = {d2, d1, d0};
    assign rdy_v = {if2.tx_ready, if1.tx_ready, if0.tx_ready};

    always #5 clk = ~clk;

    // Per-configuration parameters mirrored for the model.
    int cfg_pen [3] = '{0, 1, 1};
    int cfg_odd [3] = '{0, 0, 1};
    int cfg_stp [3] = '{1, 2, 1};

    // Frame-level model: a list of line levels and a position in it.
    bit        m_busy    [3];
    bit        m_started [3];
    bit        m_done    [3];
    int        m_pos     [3];
    int        m_len     [3];
    bit [15:0] m_frame   [3];

    // Captured {tx_done, tx_serial} per cycle for literal checks.
    logic [1:0] log0[$];
    logic [1:0] log1[$];
    logic [1:0] log2[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] lg(input int d, input int k);
        logic [1:0] r;
        r = 2'bxx;
        case (d)
            0: if (k >= 0 && k < log0.size()) r = log0[k];
            1: if (k >= 0 && k < log1.size()) r = log1[k];
            2: if (k >= 0 && k < log2.size()) r = log2[k];
            default: r = 2'bxx;
        endcase
        return r;
    endfunction

    function automatic int log_size(input int d);
        case (d)
            0: return log0.size();
            1: return log1.size();
            default: return log2.size();
        endcase
    endfunction

    function automatic int find_start(input int d);
        logic [1:0] e;
        for (int k = 0; k < log_size(d); k++) begin
            e = lg(d, k);
            if (e[0] == 1'b0) return k;
        end
        return -1;
    endfunction

    // Sample mid-bit of each data bit, 8 clocks per bit, start bit at index s.
    function automatic logic [7:0] decode(input int d, input int s);
        logic [7:0] r;
        logic [1:0] e;
        for (int b = 0; b < 8; b++) begin
            e = lg(d, s + 12 + 8 * b);
            r[b] = e[0];
        end
        return r;
    endfunction

    function automatic int count_done(input int d);
        int n;
        logic [1:0] e;
        n = 0;
        for (int k = 0; k < log_size(d); k++) begin
            e = lg(d, k);
            if (e[1] === 1'b1) n++;
        end
        return n;
    endfunction

    task automatic clear_logs();
        log0.delete(); log1.delete(); log2.delete();
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while (rdy_v !== 3'b111 && n < maxc) begin
            @(posedge clk); #1; n++;
        end
        chk("idle_reached", {31'd0, rdy_v === 3'b111}, 32'd1);
    endtask

    // Accept a word on the same edge as a baud_tick (periodic tick mode),
    // then change tx_data while busy, and return after n further edges.
    task automatic send_aligned(input logic [7:0] d, input int n);
        int w;
        w = 0;
        do begin @(posedge clk); w++; end while (!baud_tick && w < 40);
        chk("tick_found", {31'd0, baud_tick}, 32'd1);
        repeat (7) @(posedge clk);
        @(negedge clk);
        clear_logs();
        capture  = 1'b1;
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~d;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        fork
            // Baud tick generator: every 8 clocks, or random in random mode.
            begin : tick_gen
                int pcnt;
                pcnt = 0;
                forever begin
                    @(negedge clk);
                    if (tick_mode) begin
                        baud_tick = ($urandom_range(0, 4) == 0);
                    end else begin
                        baud_tick = (pcnt == 0);
                        pcnt = (pcnt + 1) % 8;
                    end
                end
            end
            // Model update and per-cycle comparison.
            begin : compare
                int n;
                forever begin
                    @(posedge clk);
                    for (int i = 0; i < 3; i++) begin
                        if (!rst_n) begin
                            m_busy[i] = 1'b0; m_started[i] = 1'b0;
                            m_pos[i] = 0; m_done[i] = 1'b0;
                        end else begin
                            m_done[i] = 1'b0;
                            if (!m_busy[i]) begin
                                if (tx_valid) begin
                                    m_frame[i] = '0;
                                    for (int k = 0; k < 8; k++) m_frame[i][1 + k] = tx_data[k];
                                    n = 9;
                                    if (cfg_pen[i] != 0) begin
                                        m_frame[i][n] = (^tx_data) ^ (cfg_odd[i] != 0);
                                        n++;
                                    end
                                    for (int k = 0; k < cfg_stp[i]; k++) begin
                                        m_frame[i][n] = 1'b1;
                                        n++;
                                    end
                                    m_len[i] = n;
                                    m_busy[i] = 1'b1;
                                    m_started[i] = 1'b0;
                                    m_pos[i] = 0;
                                end
                            end else if (baud_tick) begin
                                if (!m_started[i]) begin
                                    m_started[i] = 1'b1;
                                    m_pos[i] = 0;
                                end else begin
                                    m_pos[i]++;
                                    if (m_pos[i] == m_len[i]) begin
                                        m_busy[i] = 1'b0;
                                        m_started[i] = 1'b0;
                                        m_done[i] = 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    #1;
                    for (int i = 0; i < 3; i++) begin
                        chk($sformatf("serial[%0d]", i), {31'd0, ser_v[i]},
                            {31'd0, (m_busy[i] && m_started[i]) ? m_frame[i][m_pos[i]] : 1'b1});
                        chk($sformatf("ready[%0d]", i), {31'd0, rdy_v[i]}, {31'd0, !m_busy[i]});
                        chk($sformatf("busy[%0d]", i), {31'd0, bsy_v[i]}, {31'd0, m_busy[i]});
                        chk($sformatf("done[%0d]", i), {31'd0, dn_v[i]}, {31'd0, m_done[i]});
                    end
                    if (capture) begin
                        log0.push_back({dn_v[0], ser_v[0]});
                        log1.push_back({dn_v[1], ser_v[1]});
                        log2.push_back({dn_v[2], ser_v[2]});
                    end
                end
            end
            // Directed and random stimulus.
            begin : stim
                logic [9:0] a5_levels;
                logic [1:0] e;
                int errs;
                int st;
                int w;
                // Reset state.
                repeat (3) @(posedge clk);
                #1;
                chk("rst_serial", {29'd0, ser_v}, {29'd0, 3'b111});
                chk("rst_ready", {29'd0, rdy_v}, {29'd0, 3'b111});
                chk("rst_busy", {29'd0, bsy_v}, 32'd0);
                chk("rst_done", {29'd0, dn_v}, 32'd0);
                // Accept on the very first edge after reset release.
                @(negedge clk);
                rst_n = 1'b1; tx_valid = 1'b1; tx_data = 8'h5A;
                @(posedge clk); #1;
                chk("first_accept_busy", {29'd0, bsy_v}, {29'd0, 3'b111});
                @(negedge clk);
                tx_valid = 1'b0;
                wait_idle(300);

                // 0xA5, accept coincident with a tick.
                send_aligned(8'hA5, 110);
                @(negedge clk); capture = 1'b0;
                errs = 0;
                for (int k = 0; k < 8; k++) begin
                    e = lg(0, k);
                    if (e[0] !== 1'b1) errs++;
                end
                chk("armed_high_8", errs, 32'd0);
                a5_levels = 10'b11_0100_1010; // index b = level of bit period b
                for (int b = 0; b < 10; b++) begin
                    errs = 0;
                    for (int c = 0; c < 8; c++) begin
                        e = lg(0, 8 + 8 * b + c);
                        if (e[0] !== a5_levels[b]) errs++;
                    end
                    chk($sformatf("a5_level%0d", b), errs, 32'd0);
                end
                e = lg(0, 88);
                chk("a5_done_pos", {31'd0, e[1]}, 32'd1);
                chk("a5_done_cnt", count_done(0), 32'd1);

                // 0x07 on parity configurations.
                send_aligned(8'h07, 115);
                @(negedge clk); capture = 1'b0;
                e = lg(1, 84);
                chk("even_parity_07", {31'd0, e[0]}, 32'd1);
                e = lg(2, 84);
                chk("odd_parity_07", {31'd0, e[0]}, 32'd0);
                errs = 0;
                for (int k = 88; k < 104; k++) begin
                    e = lg(1, k);
                    if (e !== 2'b01) errs++;
                end
                chk("stop2_high_16", errs, 32'd0);
                e = lg(1, 104);
                chk("stop2_done_pos", {31'd0, e[1]}, 32'd1);
                chk("stop2_done_cnt", count_done(1), 32'd1);
                chk("odd_decode", decode(2, 8), 32'h07);
                wait_idle(50);

                // Back-to-back 0x55 then 0xAA with tx_valid held high.
                @(negedge clk);
                clear_logs();
                capture = 1'b1; tx_data = 8'h55; tx_valid = 1'b1;
                @(negedge clk);
                tx_data = 8'hAA;
                w = 0;
                do begin @(posedge clk); #1; w++; end while (dn_v[1] !== 1'b1 && w < 400);
                chk("b2b_first_done", {31'd0, dn_v[1]}, 32'd1);
                @(posedge clk);
                @(negedge clk);
                tx_valid = 1'b0;
                wait_idle(400);
                repeat (2) @(posedge clk);
                @(negedge clk); capture = 1'b0;
                st = find_start(0);
                chk("b2b_byte1", decode(0, st), 32'h55);
                chk("b2b_byte2", decode(0, st + 88), 32'hAA);
                e = lg(0, st + 80);
                chk("b2b_done1_pos", {31'd0, e[1]}, 32'd1);
                chk("b2b_done_cnt", count_done(0), 32'd2);

                // Reset during data bit 3 of 0xA5, then send 0x3C.
                send_aligned(8'hA5, 42);
                #1;
                chk("pre_rst_bit3", {31'd0, ser_v[0]}, 32'd0);
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                chk("abort_serial", {31'd0, ser_v[0]}, 32'd1);
                chk("abort_ready", {31'd0, rdy_v[0]}, 32'd1);
                chk("abort_busy", {31'd0, bsy_v[0]}, 32'd0);
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                repeat (20) @(posedge clk);
                chk("abort_no_done", count_done(0), 32'd0);
                @(negedge clk); capture = 1'b0;
                send_aligned(8'h3C, 100);
                @(negedge clk); capture = 1'b0;
                chk("post_rst_start", find_start(0), 32'd8);
                chk("post_rst_byte", decode(0, 8), 32'h3C);
                e = lg(0, 88);
                chk("post_rst_done", {31'd0, e[1]}, 32'd1);

                // Random traffic: random ticks, valid, data and reset pulses.
                tick_mode = 1'b1;
                for (int c = 0; c < 3000; c++) begin
                    @(negedge clk);
                    tx_valid = ($urandom_range(0, 2) == 0);
                    tx_data  = 8'($urandom);
                    rst_n    = ($urandom_range(0, 499) != 0);
                end
                @(negedge clk);
                tx_valid = 1'b0; rst_n = 1'b1; tick_mode = 1'b0;
                wait_idle(400);
                repeat (3) @(posedge clk);
            end
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
